// File: rtl/logic_lut_pkg.sv
// -----------------------------------------------------------------------------
// logic_lut_pkg
//   Shared types and width helpers for the programmable LUT engine.
//   - state_e : top-level sweep FSM states
//   - sig_w() : width of one channel's ones-count signature
//   - ch_w()  : width of the channel-select field on the config port
// -----------------------------------------------------------------------------
package logic_lut_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SWEEP = 2'd1,
    S_DONE  = 2'd2
  } state_e;

  // A table of 2**n_in ones needs n_in+1 bits to count without overflow.
  function automatic int sig_w(input int n_in);
    return n_in + 1;
  endfunction

  // The select field is one code wider than strictly needed for N_CH channels,
  // so an out-of-range index can always be presented and rejected.
  function automatic int ch_w(input int n_ch);
    return $clog2(n_ch + 1);
  endfunction

endpackage

// File: rtl/logic_lut_channel.sv
// -----------------------------------------------------------------------------
// logic_lut_channel
//   One independent output channel: a 2**N_IN-entry truth table register,
//   a registered lookup (res / res_n updated together) and a ones-count
//   accumulator used by the exhaustive sweep.
// Ports
//   clk, rst_n   clock, asynchronous active-low reset
//   wr_en        load wr_table into the truth table this edge
//   wr_table     new truth table, bit k = output for input code k
//   eval_en      perform a lookup of eval_code this edge
//   eval_code    input code to look up
//   acc_clr      clear the sweep accumulator (start of sweep)
//   acc_en       add tbl[acc_code] to the accumulator
//   acc_code     sweep index
//   res, res_n   registered lookup result and its complement
//   acc          accumulator value
// -----------------------------------------------------------------------------
module logic_lut_channel
  import logic_lut_pkg::*;
#(
  parameter  int N_IN  = 4,
  localparam int DEPTH = 2 ** N_IN,
  localparam int SIG_W = sig_w(N_IN)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [DEPTH-1:0] wr_table,
  input  logic             eval_en,
  input  logic [N_IN-1:0]  eval_code,
  input  logic             acc_clr,
  input  logic             acc_en,
  input  logic [N_IN-1:0]  acc_code,
  output logic             res,
  output logic             res_n,
  output logic [SIG_W-1:0] acc
);

  logic [DEPTH-1:0] tbl_q, tbl_d;
  logic             res_q, res_d;
  logic             res_n_q, res_n_d;
  logic [SIG_W-1:0] acc_q, acc_d;

  always_comb begin
    tbl_d   = tbl_q;
    res_d   = res_q;
    res_n_d = res_n_q;
    acc_d   = acc_q;

    if (wr_en) begin
      tbl_d = wr_table;
    end

    // Lookup reads tbl_q, so a write on the same edge is not yet visible.
    if (eval_en) begin
      res_d   = tbl_q[eval_code];
      res_n_d = ~tbl_q[eval_code];
    end

    if (acc_clr) begin
      acc_d = '0;
    end else if (acc_en) begin
      acc_d = acc_q + SIG_W'(tbl_q[acc_code]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tbl_q   <= '0;
      res_q   <= 1'b0;
      res_n_q <= 1'b1;
      acc_q   <= '0;
    end else begin
      tbl_q   <= tbl_d;
      res_q   <= res_d;
      res_n_q <= res_n_d;
      acc_q   <= acc_d;
    end
  end

  assign res   = res_q;
  assign res_n = res_n_q;
  assign acc   = acc_q;

endmodule

// File: rtl/logic_lut_engine.sv
// -----------------------------------------------------------------------------
// logic_lut_engine
//   N_CH independent runtime-programmable N_IN-input truth tables with a
//   valid/ready evaluate path and a built-in exhaustive sweep that walks all
//   2**N_IN codes and reports a per-channel ones-count signature.
// Ports
//   clk, rst_n               clock, asynchronous active-low reset
//   cfg_we/cfg_ch/cfg_table  table write (IDLE only, cfg_ch < N_CH)
//   cfg_err                  1-cycle pulse after a rejected write
//   in_valid/in_ready/in_data   evaluate request (ready only in IDLE)
//   out_valid, out, out_n    registered result, latency 1, held between results
//   sweep_start              start a sweep (honoured in IDLE only)
//   sweep_busy               high in SWEEP and DONE
//   sweep_done               1-cycle pulse when sweep_sig is updated
//   sweep_sig                channel c count at [c*(N_IN+1) +: N_IN+1]
// -----------------------------------------------------------------------------
module logic_lut_engine
  import logic_lut_pkg::*;
#(
  parameter  int N_IN  = 4,
  parameter  int N_CH  = 2,
  localparam int DEPTH = 2 ** N_IN,
  localparam int SIG_W = sig_w(N_IN),
  localparam int CH_W  = ch_w(N_CH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cfg_we,
  input  logic [CH_W-1:0]       cfg_ch,
  input  logic [DEPTH-1:0]      cfg_table,
  output logic                  cfg_err,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [N_IN-1:0]       in_data,
  output logic                  out_valid,
  output logic [N_CH-1:0]       out,
  output logic [N_CH-1:0]       out_n,
  input  logic                  sweep_start,
  output logic                  sweep_busy,
  output logic                  sweep_done,
  output logic [N_CH*SIG_W-1:0] sweep_sig
);

  state_e                 state_q, state_d;
  logic [N_IN-1:0]        idx_q, idx_d;
  logic                   sweep_done_q, sweep_done_d;
  logic [N_CH*SIG_W-1:0]  sweep_sig_q, sweep_sig_d;
  logic                   out_valid_q, out_valid_d;
  logic                   cfg_err_q, cfg_err_d;

  logic                   idle;
  logic                   accept;
  logic                   ch_in_range;
  logic                   cfg_ok;
  logic                   acc_clr;
  logic                   acc_en;
  logic [N_CH-1:0]        wr_en;
  logic [N_CH-1:0]        res;
  logic [N_CH-1:0]        res_n;
  logic [N_CH*SIG_W-1:0]  acc_flat;

  assign idle        = (state_q == S_IDLE);
  assign accept      = in_valid && idle;
  assign ch_in_range = (32'(cfg_ch) < N_CH);
  assign cfg_ok      = cfg_we && idle && ch_in_range;

  // ---------------------------------------------------------------------------
  // Per-channel datapath
  // ---------------------------------------------------------------------------
  generate
    for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
      assign wr_en[gi] = cfg_ok && (32'(cfg_ch) == gi);

      logic [SIG_W-1:0] acc_ch;

      logic_lut_channel #(
        .N_IN (N_IN)
      ) u_channel (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_en     (wr_en[gi]),
        .wr_table  (cfg_table),
        .eval_en   (accept),
        .eval_code (in_data),
        .acc_clr   (acc_clr),
        .acc_en    (acc_en),
        .acc_code  (idx_q),
        .res       (res[gi]),
        .res_n     (res_n[gi]),
        .acc       (acc_ch)
      );

      assign acc_flat[gi*SIG_W +: SIG_W] = acc_ch;
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Sweep FSM next-state
  //   IDLE  --start--> SWEEP (idx and accumulators cleared)
  //   SWEEP one code per cycle; the edge that consumes the last code enters DONE
  //   DONE  publishes the accumulators and pulses sweep_done on leaving
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    sweep_done_d = 1'b0;
    sweep_sig_d  = sweep_sig_q;
    acc_clr      = 1'b0;
    acc_en       = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (sweep_start) begin
          state_d = S_SWEEP;
          idx_d   = '0;
          acc_clr = 1'b1;
        end
      end
      S_SWEEP: begin
        acc_en = 1'b1;
        if (&idx_q) begin
          state_d = S_DONE;
        end else begin
          idx_d = idx_q + N_IN'(1);
        end
      end
      S_DONE: begin
        sweep_sig_d  = acc_flat;
        sweep_done_d = 1'b1;
        state_d      = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      idx_q        <= '0;
      sweep_done_q <= 1'b0;
      sweep_sig_q  <= '0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      sweep_done_q <= sweep_done_d;
      sweep_sig_q  <= sweep_sig_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Handshake status flops
  // ---------------------------------------------------------------------------
  always_comb begin
    out_valid_d = accept;
    // Any write strobe that does not land (busy or bad channel) is flagged.
    cfg_err_d   = cfg_we && !cfg_ok;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      cfg_err_q   <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      cfg_err_q   <= cfg_err_d;
    end
  end

  assign in_ready   = idle;
  assign sweep_busy = !idle;
  assign sweep_done = sweep_done_q;
  assign sweep_sig  = sweep_sig_q;
  assign out_valid  = out_valid_q;
  assign cfg_err    = cfg_err_q;
  assign out        = res;
  assign out_n      = res_n;

endmodule

// File: tb/tb_logic_lut_engine.sv
module tb_logic_lut_engine;

  localparam int N_IN  = 4;
  localparam int N_CH  = 2;
  localparam int DEPTH = 16;
  localparam int SIG_W = 5;

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b0;
  logic                  cfg_we = 1'b0;
  logic [1:0]            cfg_ch = '0;
  logic [DEPTH-1:0]      cfg_table = '0;
  logic                  cfg_err;
  logic                  in_valid = 1'b0;
  logic                  in_ready;
  logic [N_IN-1:0]       in_data = '0;
  logic                  out_valid;
  logic [N_CH-1:0]       out;
  logic [N_CH-1:0]       out_n;
  logic                  sweep_start = 1'b0;
  logic                  sweep_busy;
  logic                  sweep_done;
  logic [N_CH*SIG_W-1:0] sweep_sig;

  logic_lut_engine #(.N_IN(N_IN), .N_CH(N_CH)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cfg_we      (cfg_we),
    .cfg_ch      (cfg_ch),
    .cfg_table   (cfg_table),
    .cfg_err     (cfg_err),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .out_valid   (out_valid),
    .out         (out),
    .out_n       (out_n),
    .sweep_start (sweep_start),
    .sweep_busy  (sweep_busy),
    .sweep_done  (sweep_done),
    .sweep_sig   (sweep_sig)
  );

  always #5 clk = ~clk;

  // Reference model: bench-side copy of the truth tables.
  logic [DEPTH-1:0] model_tbl [N_CH];
  // Scoreboard entry: {code[3:0], out[1:0], out_n[1:0]}
  logic [7:0]       exp_q [$];

  int n_cmp = 0;
  int n_err = 0;

  function automatic logic [1:0] model_out(input logic [3:0] code);
    logic [1:0] o;
    for (int c = 0; c < N_CH; c++) o[c] = model_tbl[c][code];
    return o;
  endfunction

  function automatic logic [9:0] model_sig();
    logic [9:0] s;
    for (int c = 0; c < N_CH; c++) s[c*SIG_W +: SIG_W] = 5'($countones(model_tbl[c]));
    return s;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg_write(input logic [1:0] ch, input logic [15:0] t);
    cfg_we = 1'b1; cfg_ch = ch; cfg_table = t;
    tick();
    cfg_we = 1'b0;
  endtask

  // Drive an eval request for the coming edge and record the expected result.
  task automatic push_eval(input logic [3:0] code);
    logic [1:0] o;
    o = model_out(code);
    in_valid = 1'b1; in_data = code;
    exp_q.push_back({code, o, ~o});
  endtask

  task automatic run_sweep(output int cyc);
    sweep_start = 1'b1;
    tick();
    sweep_start = 1'b0;
    cyc = 0;
    while (sweep_done !== 1'b1 && cyc < 40) begin
      tick();
      cyc++;
    end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_reset();
    logic [7:0] e;
    cfg_write(2'd0, 16'hFFFF);
    in_valid = 1'b1; in_data = 4'h3;
    tick();
    in_valid = 1'b0;
    n_cmp++; if (out !== 2'b01) begin n_err++; $display("FAIL reset_pre_out: out=%b required 01", out); end
    #2; rst_n = 1'b0; #1;
    n_cmp++; if (out !== 2'b00 || out_n !== 2'b11) begin n_err++; $display("FAIL reset_out: out=%b out_n=%b required 00/11", out, out_n); end
    n_cmp++; if (out_valid !== 1'b0 || cfg_err !== 1'b0 || sweep_done !== 1'b0) begin n_err++; $display("FAIL reset_pulses: out_valid=%b cfg_err=%b sweep_done=%b required 0/0/0", out_valid, cfg_err, sweep_done); end
    n_cmp++; if (in_ready !== 1'b1 || sweep_busy !== 1'b0 || sweep_sig !== 10'd0) begin n_err++; $display("FAIL reset_state: in_ready=%b busy=%b sig=%h required 1/0/000", in_ready, sweep_busy, sweep_sig); end
    @(negedge clk); rst_n = 1'b1;
    for (int c = 0; c < N_CH; c++) model_tbl[c] = '0;
    exp_q.delete();
    tick();
    push_eval(4'hF);
    tick();
    in_valid = 1'b0;
    n_cmp++;
    if (out_valid !== 1'b1 || exp_q.size() == 0) begin n_err++; $display("FAIL reset_eval_valid: out_valid=%b queued=%0d required 1", out_valid, exp_q.size()); end
    else begin
      e = exp_q.pop_front();
      n_cmp++; if ({out, out_n} !== e[3:0]) begin n_err++; $display("FAIL reset_tables code=%h: out=%b out_n=%b required %b/%b", e[7:4], out, out_n, e[3:2], e[1:0]); end
    end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_basic_eval();
    logic [3:0] codes [3];
    logic [7:0] e;
    codes = '{4'h0, 4'h1, 4'hF};
    cfg_write(2'd0, 16'h8000);
    n_cmp++; if (cfg_err !== 1'b0) begin n_err++; $display("FAIL basic_cfg0_err: cfg_err=%b required 0", cfg_err); end
    model_tbl[0] = 16'h8000;
    cfg_write(2'd1, 16'hFFFE);
    n_cmp++; if (cfg_err !== 1'b0) begin n_err++; $display("FAIL basic_cfg1_err: cfg_err=%b required 0", cfg_err); end
    model_tbl[1] = 16'hFFFE;
    for (int i = 0; i < 3; i++) begin
      push_eval(codes[i]);
      tick();
      in_valid = 1'b0;
      n_cmp++;
      if (out_valid !== 1'b1 || exp_q.size() == 0) begin n_err++; $display("FAIL basic_valid: out_valid=%b queued=%0d required 1", out_valid, exp_q.size()); end
      else begin
        e = exp_q.pop_front();
        n_cmp++; if ({out, out_n} !== e[3:0]) begin n_err++; $display("FAIL basic_out code=%h: out=%b out_n=%b required %b/%b", e[7:4], out, out_n, e[3:2], e[1:0]); end
        tick();
        n_cmp++; if (out_valid !== 1'b0 || {out, out_n} !== e[3:0]) begin n_err++; $display("FAIL basic_hold code=%h: out_valid=%b out=%b out_n=%b required 0 %b/%b", e[7:4], out_valid, out, out_n, e[3:2], e[1:0]); end
      end
    end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_sweep();
    int cyc;
    logic [9:0] exp_sig;
    exp_sig = model_sig();
    sweep_start = 1'b1;
    tick();
    sweep_start = 1'b0;
    in_valid = 1'b1; in_data = 4'h5;
    cyc = 0;
    while (sweep_done !== 1'b1 && cyc < 40) begin
      n_cmp++; if (in_ready !== 1'b0 || sweep_busy !== 1'b1 || out_valid !== 1'b0) begin n_err++; $display("FAIL sweep_hs cyc=%0d: in_ready=%b busy=%b out_valid=%b required 0/1/0", cyc, in_ready, sweep_busy, out_valid); end
      sweep_start = (cyc == 5);
      tick();
      cyc++;
    end
    in_valid = 1'b0; sweep_start = 1'b0;
    n_cmp++; if (cyc != 17) begin n_err++; $display("FAIL sweep_latency: cycles=%0d required 17", cyc); end
    n_cmp++; if (sweep_sig !== exp_sig) begin n_err++; $display("FAIL sweep_sig: sig=%h required %h", sweep_sig, exp_sig); end
    n_cmp++; if (in_ready !== 1'b1 || sweep_busy !== 1'b0) begin n_err++; $display("FAIL sweep_idle: in_ready=%b busy=%b required 1/0", in_ready, sweep_busy); end
    tick();
    n_cmp++; if (sweep_done !== 1'b0 || sweep_sig !== exp_sig) begin n_err++; $display("FAIL sweep_pulse: done=%b sig=%h required 0 %h", sweep_done, sweep_sig, exp_sig); end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_cfg_err();
    int cyc;
    logic [3:0] codes [4];
    logic [7:0] e;
    codes = '{4'h0, 4'h1, 4'h2, 4'hF};
    sweep_start = 1'b1;
    tick();
    sweep_start = 1'b0;
    tick();
    cfg_write(2'd0, 16'hFFFF);
    n_cmp++; if (cfg_err !== 1'b1) begin n_err++; $display("FAIL cfg_err_busy: cfg_err=%b required 1", cfg_err); end
    tick();
    n_cmp++; if (cfg_err !== 1'b0) begin n_err++; $display("FAIL cfg_err_busy_pulse: cfg_err=%b required 0", cfg_err); end
    cyc = 0;
    while (sweep_done !== 1'b1 && cyc < 40) begin tick(); cyc++; end
    n_cmp++; if (sweep_done !== 1'b1 || sweep_sig !== model_sig()) begin n_err++; $display("FAIL cfg_err_sweep: done=%b sig=%h required 1 %h", sweep_done, sweep_sig, model_sig()); end
    cfg_write(2'd2, 16'h1234);
    n_cmp++; if (cfg_err !== 1'b1) begin n_err++; $display("FAIL cfg_err_ch: cfg_err=%b required 1", cfg_err); end
    tick();
    n_cmp++; if (cfg_err !== 1'b0) begin n_err++; $display("FAIL cfg_err_ch_pulse: cfg_err=%b required 0", cfg_err); end
    for (int i = 0; i < 4; i++) begin
      push_eval(codes[i]);
      tick();
      n_cmp++;
      if (out_valid !== 1'b1 || exp_q.size() == 0) begin n_err++; $display("FAIL cfg_err_valid: out_valid=%b queued=%0d required 1", out_valid, exp_q.size()); end
      else begin
        e = exp_q.pop_front();
        n_cmp++; if ({out, out_n} !== e[3:0]) begin n_err++; $display("FAIL cfg_err_tables code=%h: out=%b out_n=%b required %b/%b", e[7:4], out, out_n, e[3:2], e[1:0]); end
      end
    end
    in_valid = 1'b0;
    tick();
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_same_cycle();
    int cyc;
    logic [7:0] e;
    for (int k = 0; k < 2; k++) begin
      if (k == 0) begin
        cfg_we = 1'b1; cfg_ch = 2'd0; cfg_table = 16'h6996;
      end
      push_eval(4'h1);
      tick();
      cfg_we = 1'b0; in_valid = 1'b0;
      model_tbl[0] = 16'h6996;
      n_cmp++;
      if (out_valid !== 1'b1 || exp_q.size() == 0) begin n_err++; $display("FAIL same_valid k=%0d: out_valid=%b queued=%0d required 1", k, out_valid, exp_q.size()); end
      else begin
        e = exp_q.pop_front();
        n_cmp++; if ({out, out_n} !== e[3:0]) begin n_err++; $display("FAIL same_out k=%0d code=%h: out=%b out_n=%b required %b/%b", k, e[7:4], out, out_n, e[3:2], e[1:0]); end
      end
    end
    run_sweep(cyc);
    n_cmp++; if (cyc != 17 || sweep_sig !== {5'd15, 5'd8}) begin n_err++; $display("FAIL same_sweep: cycles=%0d sig=%h required 17 %h", cyc, sweep_sig, {5'd15, 5'd8}); end
    cfg_write(2'd0, 16'hFFFF); model_tbl[0] = 16'hFFFF;
    cfg_write(2'd1, 16'h0000); model_tbl[1] = 16'h0000;
    run_sweep(cyc);
    n_cmp++; if (cyc != 17 || sweep_sig !== model_sig()) begin n_err++; $display("FAIL full_sweep: cycles=%0d sig=%h required 17 %h", cyc, sweep_sig, model_sig()); end
    tick();
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_back_to_back();
    int cyc;
    logic [15:0] t;
    logic [7:0] e;
    for (int c = 0; c < N_CH; c++) begin
      t = 16'($urandom);
      cfg_write(2'(c), t);
      model_tbl[c] = t;
    end
    for (int i = 0; i < 24; i++) begin
      push_eval(4'($urandom_range(0, 15)));
      tick();
      n_cmp++;
      if (out_valid !== 1'b1 || exp_q.size() == 0) begin n_err++; $display("FAIL b2b_valid i=%0d: out_valid=%b queued=%0d required 1", i, out_valid, exp_q.size()); end
      else begin
        e = exp_q.pop_front();
        n_cmp++; if ({out, out_n} !== e[3:0]) begin n_err++; $display("FAIL b2b_out i=%0d code=%h: out=%b out_n=%b required %b/%b", i, e[7:4], out, out_n, e[3:2], e[1:0]); end
      end
    end
    in_valid = 1'b0;
    tick();
    n_cmp++; if (out_valid !== 1'b0 || exp_q.size() != 0) begin n_err++; $display("FAIL b2b_drain: out_valid=%b queued=%0d required 0/0", out_valid, exp_q.size()); end
    run_sweep(cyc);
    n_cmp++; if (cyc != 17 || sweep_sig !== model_sig()) begin n_err++; $display("FAIL b2b_sweep: cycles=%0d sig=%h required 17 %h", cyc, sweep_sig, model_sig()); end
    tick();
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_reset_mid_sweep();
    bit seen;
    logic [7:0] e;
    sweep_start = 1'b1;
    tick();
    sweep_start = 1'b0;
    repeat (8) tick();
    #2; rst_n = 1'b0; #1;
    n_cmp++; if (sweep_sig !== 10'd0 || sweep_busy !== 1'b0 || in_ready !== 1'b1) begin n_err++; $display("FAIL midrst_state: sig=%h busy=%b in_ready=%b required 000/0/1", sweep_sig, sweep_busy, in_ready); end
    @(negedge clk); rst_n = 1'b1;
    for (int c = 0; c < N_CH; c++) model_tbl[c] = '0;
    exp_q.delete();
    seen = 1'b0;
    repeat (24) begin
      tick();
      if (sweep_done === 1'b1) seen = 1'b1;
    end
    n_cmp++; if (seen !== 1'b0) begin n_err++; $display("FAIL midrst_done: sweep_done seen=%b required 0", seen); end
    n_cmp++; if (sweep_sig !== 10'd0 || in_ready !== 1'b1) begin n_err++; $display("FAIL midrst_after: sig=%h in_ready=%b required 000/1", sweep_sig, in_ready); end
    push_eval(4'hF);
    tick();
    in_valid = 1'b0;
    n_cmp++;
    if (out_valid !== 1'b1 || exp_q.size() == 0) begin n_err++; $display("FAIL midrst_valid: out_valid=%b queued=%0d required 1", out_valid, exp_q.size()); end
    else begin
      e = exp_q.pop_front();
      n_cmp++; if ({out, out_n} !== e[3:0]) begin n_err++; $display("FAIL midrst_tables code=%h: out=%b out_n=%b required %b/%b", e[7:4], out, out_n, e[3:2], e[1:0]); end
    end
  endtask

  // ---------------------------------------------------------------------------
  initial begin
    for (int c = 0; c < N_CH; c++) model_tbl[c] = '0;
    repeat (2) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    tick();
    test_reset();
    test_basic_eval();
    test_sweep();
    test_cfg_err();
    test_same_cycle();
    test_back_to_back();
    test_reset_mid_sweep();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
